// File: rtl/mips_pkg.sv
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared constants for the MIPS pipeline write-back datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic [1:0] WD_SEL_E_RES = 2'd0;
  localparam logic [1:0] WD_SEL_M_RES = 2'd1;
  localparam logic [1:0] WD_SEL_EXT32 = 2'd2;
  localparam logic [1:0] WD_SEL_PC8   = 2'd3;

  localparam int GRF_ADDR_W = 5;

  // Write-back value select, shared by the stage and anything forwarding from it.
  function automatic logic [31:0] wd_select(
    input logic [1:0]  sel,
    input logic [31:0] e_res,
    input logic [31:0] m_res,
    input logic [31:0] ext32,
    input logic [31:0] pc8
  );
    logic [31:0] w_res;
    unique case (sel)
      WD_SEL_E_RES: w_res = e_res;
      WD_SEL_M_RES: w_res = m_res;
      WD_SEL_EXT32: w_res = ext32;
      WD_SEL_PC8:   w_res = pc8;
    endcase
    return w_res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/grf_array.sv
// ============================================================================
// Module   : grf_array
// Purpose  : 2R1W register storage with hard-wired zero entry and sync clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module grf_array
  import mips_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = GRF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wa,
  input  logic [WIDTH-1:0]  i_wd,
  input  logic [ADDR_W-1:0] i_ra1,
  input  logic [ADDR_W-1:0] i_ra2,
  output logic [WIDTH-1:0]  o_rd1,
  output logic [WIDTH-1:0]  o_rd2
);

  logic [WIDTH-1:0] w_rows [DEPTH];

  // Entry 0 has no storage; it is a constant zero row.
  assign w_rows[0] = '0;

  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_row
    logic [WIDTH-1:0] r_row;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_row <= '0;
      end else if (i_we && (i_wa == ADDR_W'(gi))) begin
        r_row <= i_wd;
      end
    end

    assign w_rows[gi] = r_row;
  end

  assign o_rd1 = w_rows[i_ra1];
  assign o_rd2 = w_rows[i_ra2];

endmodule

`default_nettype wire

// File: rtl/grf_writeback.sv
// ============================================================================
// Module   : grf_writeback
// Purpose  : W stage - write-data select, GRF commit with D-read bypass,
//            commit trace and retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module grf_writeback
  import mips_pkg::*;
#(
  parameter int          GRF_DEPTH = 32,
  parameter logic [31:0] PC_RESET  = 32'h0000_3000
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  W_GRFWE,
  input  logic [1:0]            W_GRF_WD_W_Sel,
  input  logic [31:0]           W_E_RES,
  input  logic [31:0]           W_M_RES,
  input  logic [31:0]           W_ext32,
  input  logic [31:0]           W_pc8,
  input  logic [GRF_ADDR_W-1:0] W_GRF_A3,
  input  logic [31:0]           W_Exam_InstrAddr,
  input  logic [GRF_ADDR_W-1:0] D_GRF_A1,
  input  logic [GRF_ADDR_W-1:0] D_GRF_A2,
  output logic [31:0]           D_GRF_RD1,
  output logic [31:0]           D_GRF_RD2,
  output logic [31:0]           W_GRF_WD,
  output logic                  Exam_WE,
  output logic [GRF_ADDR_W-1:0] Exam_A3,
  output logic [31:0]           Exam_WD,
  output logic [31:0]           Exam_PC,
  output logic [31:0]           Retire_Count
);

  // A bubble is marked by PC zero, independent of the reset vector.
  localparam logic [31:0] c_bubble_pc = PC_RESET & 32'h0;

  logic        w_we_eff;
  logic [31:0] w_arr_rd1;
  logic [31:0] w_arr_rd2;
  logic [31:0] r_retire_count;

  assign W_GRF_WD = wd_select(W_GRF_WD_W_Sel, W_E_RES, W_M_RES, W_ext32, W_pc8);
  assign w_we_eff = W_GRFWE && (W_GRF_A3 != '0) && !RESET;

  grf_array #(
    .DEPTH  (GRF_DEPTH),
    .WIDTH  (32),
    .ADDR_W (GRF_ADDR_W)
  ) u_grf_array (
    .clk   (clk),
    .rst   (RESET),
    .i_we  (w_we_eff),
    .i_wa  (W_GRF_A3),
    .i_wd  (W_GRF_WD),
    .i_ra1 (D_GRF_A1),
    .i_ra2 (D_GRF_A2),
    .o_rd1 (w_arr_rd1),
    .o_rd2 (w_arr_rd2)
  );

  // Write-before-read: the W commit is visible to D in the same cycle.
  always_comb begin
    D_GRF_RD1 = w_arr_rd1;
    D_GRF_RD2 = w_arr_rd2;
    if (D_GRF_A1 == '0) begin
      D_GRF_RD1 = '0;
    end else if (w_we_eff && (W_GRF_A3 == D_GRF_A1)) begin
      D_GRF_RD1 = W_GRF_WD;
    end
    if (D_GRF_A2 == '0) begin
      D_GRF_RD2 = '0;
    end else if (w_we_eff && (W_GRF_A3 == D_GRF_A2)) begin
      D_GRF_RD2 = W_GRF_WD;
    end
  end

  assign Exam_WE = w_we_eff;
  assign Exam_A3 = W_GRF_A3;
  assign Exam_WD = W_GRF_WD;
  assign Exam_PC = W_Exam_InstrAddr;

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_retire_count <= '0;
    end else if (W_Exam_InstrAddr != c_bubble_pc) begin
      r_retire_count <= r_retire_count + 32'd1;
    end
  end

  assign Retire_Count = r_retire_count;

endmodule

`default_nettype wire
